// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser with three finite inventories (10/5/1 units).
// Define CHANGE_DISP_GAP_EN to insert one idle GAP cycle after every ejected coin.
module change_dispenser #(
  parameter logic [3:0] INIT_A = 4'd8,
  parameter logic [3:0] INIT_B = 4'd8,
  parameter logic [3:0] INIT_C = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [5:0] amount,
  input  logic       refill,
  output logic       coin_a,
  output logic       coin_b,
  output logic       coin_c,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [5:0] remaining,
  output logic       empty_a,
  output logic       empty_b,
  output logic       empty_c
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DISP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_a_q, cnt_a_d;
  logic [3:0] cnt_b_q, cnt_b_d;
  logic [3:0] cnt_c_q, cnt_c_d;
  logic [5:0] rem_q, rem_d;
  logic       coin_a_q, coin_a_d;
  logic       coin_b_q, coin_b_d;
  logic       coin_c_q, coin_c_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       short_q, short_d;
  logic [1:0] after_coin;

`ifdef CHANGE_DISP_GAP_EN
  assign after_coin = GAP;
`else
  assign after_coin = DISP;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    cnt_c_d  = cnt_c_q;
    rem_d    = rem_q;
    coin_a_d = 1'b0;
    coin_b_d = 1'b0;
    coin_c_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    short_d  = short_q;
    case (state_q)
      IDLE: begin
        // Refill takes priority over a simultaneous request.
        if (refill) begin
          cnt_a_d = INIT_A;
          cnt_b_d = INIT_B;
          cnt_c_d = INIT_C;
        end else if (req) begin
          rem_d   = amount;
          short_d = 1'b0;
          busy_d  = 1'b1;
          state_d = DISP;
        end
      end
      DISP: begin
        if (rem_q >= 6'd10 && cnt_a_q != 4'd0) begin
          coin_a_d = 1'b1;
          rem_d    = rem_q - 6'd10;
          cnt_a_d  = cnt_a_q - 4'd1;
          state_d  = after_coin;
        end else if (rem_q >= 6'd5 && cnt_b_q != 4'd0) begin
          coin_b_d = 1'b1;
          rem_d    = rem_q - 6'd5;
          cnt_b_d  = cnt_b_q - 4'd1;
          state_d  = after_coin;
        end else if (rem_q != 6'd0 && cnt_c_q != 4'd0) begin
          coin_c_d = 1'b1;
          rem_d    = rem_q - 6'd1;
          cnt_c_d  = cnt_c_q - 4'd1;
          state_d  = after_coin;
        end else begin
          done_d  = 1'b1;
          short_d = (rem_q != 6'd0);
          state_d = DONE;
        end
      end
      GAP: state_d = DISP;
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_a_q  <= INIT_A;
      cnt_b_q  <= INIT_B;
      cnt_c_q  <= INIT_C;
      rem_q    <= 6'd0;
      coin_a_q <= 1'b0;
      coin_b_q <= 1'b0;
      coin_c_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      cnt_c_q  <= cnt_c_d;
      rem_q    <= rem_d;
      coin_a_q <= coin_a_d;
      coin_b_q <= coin_b_d;
      coin_c_q <= coin_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      short_q  <= short_d;
    end
  end

  assign coin_a    = coin_a_q;
  assign coin_b    = coin_b_q;
  assign coin_c    = coin_c_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign short     = short_q;
  assign remaining = rem_q;
  assign empty_a   = (cnt_a_q == 4'd0);
  assign empty_b   = (cnt_b_q == 4'd0);
  assign empty_c   = (cnt_c_q == 4'd0);

endmodule
